// File: rtl/sdram_arb_pkg.sv
// Shared slot timing constants and grant/state encodings for the SDRAM slot arbiter.
package sdram_arb_pkg;

   localparam int SLOT_LEN = 8;
   localparam int PHASE_W  = $clog2(SLOT_LEN);

   typedef logic [PHASE_W-1:0] phase_t;

   localparam phase_t SYNC_HIGH_PHASES = phase_t'(4);
   localparam phase_t ARB_PHASE        = phase_t'(7);
   localparam phase_t CAPTURE_PHASE    = phase_t'(7);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_VID,
      GNT_CPU
   } gnt_t;

   typedef enum logic [1:0] {
      INIT,
      WAIT,
      RUN
   } state_t;

endpackage

// File: rtl/sdram_slot_timer.sv
// Free-running 8-phase slot counter with registered sync (high in phases 0..3).
// slot_end is combinational on the last phase; no backpressure.
module sdram_slot_timer
   import sdram_arb_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   output phase_t phase,
   output logic   sync,
   output logic   slot_end
);

   phase_t phase_nxt;

   assign phase_nxt = phase + 1'b1;
   assign slot_end  = (phase == ARB_PHASE);

   // sync is registered from the next phase so it always matches the current phase
   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= '0;
         sync  <= 1'b1;
      end else begin
         phase <= phase_nxt;
         sync  <= (phase_nxt < SYNC_HIGH_PHASES);
      end
   end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Slot owner for the sdram controller: init/sync generation, video>CPU arbitration on phase 7,
// ack one cycle after sampling, read data 8 cycles after ack. Macro SDRAM_ARB_FORCED_REFRESH_EN forces idle slots.
module sdram_slot_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int INIT_SLOTS       = 40,
   parameter int REFRESH_INTERVAL = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vid_req,
   input  logic [19:0] vid_addr,
   output logic        vid_ack,
   output logic        vid_rvalid,
   output logic [15:0] vid_rdata,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [19:0] cpu_addr,
   input  logic [15:0] cpu_din,
   input  logic [1:0]  cpu_ds,
   output logic        cpu_ack,
   output logic        cpu_rvalid,
   output logic [15:0] cpu_rdata,
   output logic        mem_init,
   output logic        mem_sync,
   output logic        mem_oe,
   output logic        mem_we,
   output logic [19:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_ds,
   input  logic [15:0] mem_dout
);

   localparam int WCNT_W = $clog2(INIT_SLOTS + 1);

   if (INIT_SLOTS < 1 || REFRESH_INTERVAL < 1) begin : g_bad_cfg
      $error("sdram_slot_arbiter: INIT_SLOTS and REFRESH_INTERVAL must be at least 1");
   end

   phase_t            phase;
   logic              slot_end;
   logic              capture;
   state_t            state, state_nxt;
   logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
   gnt_t              gnt, cur_gnt;
   logic              force_ref;
   logic              vid_rd_done, cpu_rd_done;

   sdram_slot_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .phase    (phase),
      .sync     (mem_sync),
      .slot_end (slot_end)
   );

   assign capture     = (phase == CAPTURE_PHASE);
   assign mem_init    = (state == INIT);
   assign vid_rd_done = capture && (cur_gnt == GNT_VID);
   assign cpu_rd_done = capture && (cur_gnt == GNT_CPU) && mem_oe;

`ifdef SDRAM_ARB_FORCED_REFRESH_EN
   localparam int RCNT_W = $clog2(REFRESH_INTERVAL + 1);
   logic [RCNT_W-1:0] ref_cnt;

   // Counts consecutive granted slots; any idle slot lets the controller refresh
   always_ff @(posedge clk) begin
      if (reset)
         ref_cnt <= '0;
      else if (slot_end)
         ref_cnt <= (gnt == GNT_NONE) ? '0 : ref_cnt + 1'b1;
   end

   assign force_ref = (ref_cnt == RCNT_W'(REFRESH_INTERVAL));
`else
   assign force_ref = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= INIT;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      gnt          = GNT_NONE;
      case (state)
         INIT: if (slot_end) state_nxt = WAIT;
         WAIT: begin
            if (slot_end) begin
               if (wait_cnt == WCNT_W'(INIT_SLOTS - 1)) begin
                  state_nxt    = RUN;
                  wait_cnt_nxt = '0;
               end else begin
                  wait_cnt_nxt = wait_cnt + 1'b1;
               end
            end
         end
         RUN: begin
            if (slot_end && !force_ref) begin
               if (vid_req)      gnt = GNT_VID;
               else if (cpu_req) gnt = GNT_CPU;
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   // Request fields are loaded once per slot and held until the next arbitration edge
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_gnt    <= GNT_NONE;
         mem_oe     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         mem_ds     <= '0;
         vid_ack    <= 1'b0;
         cpu_ack    <= 1'b0;
         vid_rvalid <= 1'b0;
         cpu_rvalid <= 1'b0;
         vid_rdata  <= '0;
         cpu_rdata  <= '0;
      end else begin
         vid_ack    <= (gnt == GNT_VID);
         cpu_ack    <= (gnt == GNT_CPU);
         vid_rvalid <= vid_rd_done;
         cpu_rvalid <= cpu_rd_done;
         if (vid_rd_done) vid_rdata <= mem_dout;
         if (cpu_rd_done) cpu_rdata <= mem_dout;
         if (slot_end) begin
            cur_gnt <= gnt;
            case (gnt)
               GNT_VID: begin
                  mem_oe   <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= vid_addr;
                  mem_din  <= '0;
                  mem_ds   <= 2'b11;
               end
               GNT_CPU: begin
                  mem_oe   <= !cpu_we;
                  mem_we   <= cpu_we;
                  mem_addr <= cpu_addr;
                  mem_din  <= cpu_din;
                  mem_ds   <= cpu_ds;
               end
               default: begin
                  mem_oe   <= 1'b0;
                  mem_we   <= 1'b0;
                  mem_addr <= '0;
                  mem_din  <= '0;
                  mem_ds   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: slot-level reference model checked every cycle plus directed scenarios.
module tb_sdram_slot_arbiter;

   localparam int INIT_SLOTS       = 40;
   localparam int REFRESH_INTERVAL = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vid_req = 1'b0;
   logic [19:0] vid_addr = '0;
   logic        vid_ack, vid_rvalid;
   logic [15:0] vid_rdata;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [19:0] cpu_addr = '0;
   logic [15:0] cpu_din = '0;
   logic [1:0]  cpu_ds = '0;
   logic        cpu_ack, cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        mem_init, mem_sync, mem_oe, mem_we;
   logic [19:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_ds;
   logic [15:0] mem_dout = '0;

   logic [15:0] vid_data = '0;
   logic [15:0] cpu_data = '0;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   sdram_slot_arbiter #(
      .INIT_SLOTS       (INIT_SLOTS),
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .vid_req    (vid_req),
      .vid_addr   (vid_addr),
      .vid_ack    (vid_ack),
      .vid_rvalid (vid_rvalid),
      .vid_rdata  (vid_rdata),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_din    (cpu_din),
      .cpu_ds     (cpu_ds),
      .cpu_ack    (cpu_ack),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .mem_init   (mem_init),
      .mem_sync   (mem_sync),
      .mem_oe     (mem_oe),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_ds     (mem_ds),
      .mem_dout   (mem_dout)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (slot-level view) ----------------
   bit          e_init, e_sync, e_vid_ack, e_cpu_ack, e_vid_rv, e_cpu_rv, e_oe, e_we;
   logic [19:0] e_addr;
   logic [15:0] e_din, e_vid_rd, e_cpu_rd;
   logic [1:0]  e_ds;
   int          m_k, m_ends, m_cur, m_consec;
   bit          m_cur_rd, m_valid;

   initial begin
      int ph, nxt;
      bit forced;
      m_valid = 1'b0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_k = 0; m_ends = 0; m_cur = 0; m_consec = 0; m_cur_rd = 1'b0;
            e_init = 1'b1; e_sync = 1'b1;
            e_vid_ack = 0; e_cpu_ack = 0; e_vid_rv = 0; e_cpu_rv = 0;
            e_oe = 0; e_we = 0; e_addr = '0; e_din = '0; e_ds = '0;
            e_vid_rd = '0; e_cpu_rd = '0;
         end else begin
            ph = m_k % 8;
            e_vid_ack = 0; e_cpu_ack = 0; e_vid_rv = 0; e_cpu_rv = 0;
            if (ph == 7) begin
               m_ends++;
               if (m_cur == 1) begin e_vid_rv = 1; e_vid_rd = mem_dout; end
               if (m_cur == 2 && m_cur_rd) begin e_cpu_rv = 1; e_cpu_rd = mem_dout; end
               forced = 1'b0;
`ifdef SDRAM_ARB_FORCED_REFRESH_EN
               forced = (m_consec >= REFRESH_INTERVAL);
`endif
               nxt = 0;
               // one init slot plus INIT_SLOTS wait slots must complete before any grant
               if (m_ends >= INIT_SLOTS + 2 && !forced)
                  nxt = vid_req ? 1 : (cpu_req ? 2 : 0);
               m_consec = (nxt != 0) ? m_consec + 1 : 0;
               e_oe = (nxt == 1) || (nxt == 2 && !cpu_we);
               e_we = (nxt == 2) && cpu_we;
               e_addr = (nxt == 1) ? vid_addr : cpu_addr;
               e_ds = (nxt == 1) ? 2'b11 : cpu_ds;
               e_din = cpu_din;
               e_vid_ack = (nxt == 1);
               e_cpu_ack = (nxt == 2);
               m_cur = nxt;
               m_cur_rd = e_oe;
               e_init = 1'b0;
            end
            m_k++;
            e_sync = (m_k % 8) < 4;
         end
         m_valid = 1'b1;
      end
   end

   // controller stand-in: returns the owning port's data pattern
   initial forever begin
      @(negedge clk);
      mem_dout = (m_cur == 1) ? vid_data : ((m_cur == 2) ? cpu_data : 16'hDEAD);
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("mdl_init", mem_init, e_init);
         check("mdl_sync", mem_sync, e_sync);
         check("mdl_vid_ack", vid_ack, e_vid_ack);
         check("mdl_cpu_ack", cpu_ack, e_cpu_ack);
         check("mdl_vid_rvalid", vid_rvalid, e_vid_rv);
         check("mdl_cpu_rvalid", cpu_rvalid, e_cpu_rv);
         check("mdl_vid_rdata", vid_rdata, e_vid_rd);
         check("mdl_cpu_rdata", cpu_rdata, e_cpu_rd);
         check("mdl_oe", mem_oe, e_oe);
         check("mdl_we", mem_we, e_we);
         if (e_oe || e_we) begin
            check("mdl_addr", mem_addr, e_addr);
            check("mdl_ds", mem_ds, e_ds);
         end
         if (e_we) check("mdl_din", mem_din, e_din);
      end
   end

   task automatic do_req(input bit is_vid, input bit we, input logic [19:0] a, input logic [15:0] d,
                         input logic [1:0] ds, output int ack_c, output int rv_c, output logic [15:0] rd);
      bit got;
      got = 1'b0; ack_c = -1; rv_c = -1; rd = '0;
      @(negedge clk);
      if (is_vid) begin
         vid_req = 1'b1; vid_addr = a;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; cpu_ds = ds;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (is_vid ? vid_ack : cpu_ack) begin got = 1'b1; ack_c = cyc; end
      end
      if (is_vid) begin vid_req = 1'b0; check("vid_ack_seen", got, 1); end
      else begin cpu_req = 1'b0; check("cpu_ack_seen", got, 1); end
      if (!we) begin
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (is_vid ? vid_rvalid : cpu_rvalid) begin
               got = 1'b1; rv_c = cyc; rd = is_vid ? vid_rdata : cpu_rdata;
            end
         end
         if (is_vid) check("vid_rvalid_seen", got, 1);
         else check("cpu_rvalid_seen", got, 1);
      end
   endtask

   initial begin
      int rel, k, ack_k, init_hi, sync_hi, rises, held, n_rv, n_idle, idle_at;
      int ack_c, rv_c, va, vr, ca, cr;
      logic [15:0] rd, vd, cd;
      logic [1:0] idle_bus;
      bit prev_sync, got;

      repeat (3) @(negedge clk);
      check("rst_init", mem_init, 1);
      check("rst_sync", mem_sync, 1);
      check("rst_strobes", {vid_ack, cpu_ack, vid_rvalid, cpu_rvalid, mem_oe, mem_we}, 0);
      check("rst_rdata", {vid_rdata, cpu_rdata}, 0);

      // CPU write queued from release: waits out init and the wait slots
      reset = 1'b0; rel = cyc;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h12345; cpu_din = 16'hBEEF; cpu_ds = 2'b01;
      ack_k = -1; init_hi = 0; sync_hi = 0; rises = 0; prev_sync = 1'b1;
      for (int i = 0; i < 400 && ack_k < 0; i++) begin
         @(negedge clk);
         k = cyc - rel;
         if (mem_init) init_hi++;
         if (mem_sync) sync_hi++;
         if (mem_sync && !prev_sync) rises++;
         prev_sync = mem_sync;
         if (cpu_ack || vid_ack) ack_k = k;
      end
      cpu_req = 1'b0;
      check("first_ack_edge", ack_k, 336);
      check("init_cycles", init_hi, 7);
      check("sync_high_cycles", sync_hi, 168);
      check("sync_periods", rises, 42);

      held = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         if (mem_we && !mem_oe && mem_addr == 20'h12345 && mem_ds == 2'b01 && mem_din == 16'hBEEF) held++;
      end
      check("write_hold_cycles", held, 8);
      n_rv = 0;
      repeat (9) begin
         @(negedge clk);
         if (cpu_rvalid) n_rv++;
      end
      check("write_no_rvalid", n_rv, 0);

      cpu_data = 16'hA55A;
      do_req(1'b0, 1'b0, 20'h00ABC, 16'h0000, 2'b11, ack_c, rv_c, rd);
      check("cpu_read_latency", rv_c - ack_c, 8);
      check("cpu_read_data", rd, 16'hA55A);

      vid_data = 16'h5AA5; cpu_data = 16'h0F0F;
      fork
         do_req(1'b1, 1'b0, 20'h0F00D, 16'h0000, 2'b11, va, vr, vd);
         do_req(1'b0, 1'b0, 20'h00042, 16'h0000, 2'b10, ca, cr, cd);
      join
      check("simul_cpu_next_slot", ca - va, 8);
      check("simul_vid_latency", vr - va, 8);
      check("simul_vid_data", vd, 16'h5AA5);
      check("simul_cpu_data", cd, 16'h0F0F);

      // video held for 70 slots
      repeat (16) @(negedge clk);
      vid_data = 16'h7E57; vid_addr = 20'h00100; vid_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (vid_ack) got = 1'b1;
      end
      check("stream_first_ack", got, 1);
      n_idle = 0; idle_at = 0; idle_bus = 2'b11;
      for (int s = 2; s <= 70; s++) begin
         repeat (8) @(negedge clk);
         if (!vid_ack) begin n_idle++; idle_at = s; idle_bus = {mem_oe, mem_we}; end
      end
      vid_req = 1'b0;
`ifdef SDRAM_ARB_FORCED_REFRESH_EN
      check("stream_idle_count", n_idle, 1);
      check("stream_idle_slot", idle_at, 65);
      check("stream_idle_bus", idle_bus, 0);
`else
      check("stream_idle_count", n_idle, 0);
`endif

      // reset at phase 4 of a video read slot
      repeat (16) @(negedge clk);
      vid_data = 16'h1234; vid_addr = 20'h00200; vid_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (vid_ack) got = 1'b1;
      end
      vid_req = 1'b0;
      check("midrst_ack", got, 1);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_init", mem_init, 1);
      check("midrst_sync", mem_sync, 1);
      check("midrst_strobes", {vid_ack, cpu_ack, vid_rvalid, cpu_rvalid, mem_oe, mem_we}, 0);
      check("midrst_rdata", {vid_rdata, cpu_rdata}, 0);
      check("midrst_addr", mem_addr, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n_rv = 0; init_hi = 0;
      repeat (16) begin
         @(negedge clk);
         if (vid_rvalid) n_rv++;
         if (mem_init) init_hi++;
      end
      check("midrst_no_rvalid", n_rv, 0);
      check("midrst_init_again", init_hi, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
